// File: rtl/muldiv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_pkg : op codes, FSM state encoding and sizing for muldiv_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_ctrl_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int DIV_CNT_W = 6;
  localparam int MUL_CNT_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_SIGN  = 3'd3,
    ST_DZERO = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_div_iter.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl_div_iter : restoring unsigned divider, one quotient bit per step
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_ctrl_div_iter
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  step,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  last_step
);

  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] dsr;
  logic [DIV_CNT_W-1:0]  cnt;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH:0]   diff;

  // quo starts as the dividend and shifts out MSB-first while quotient bits shift in
  always_comb begin
    shifted = {rem, quo[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, dsr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (start) begin
      rem <= '0;
      quo <= dividend;
      dsr <= divisor;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (!diff[DATA_WIDTH]) begin
        rem <= diff[DATA_WIDTH-1:0];
        quo <= {quo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[DATA_WIDTH-1:0];
        quo <= {quo[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign last_step = step && (cnt == DIV_CNT_W'(DATA_WIDTH - 1));
  assign quotient  = quo;
  assign remainder = rem;

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl : MULT/MULTU/DIV/DIVU sequencer, HI/LO owner, pipeline stall source
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  output logic                  stall_req,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  state_t state;
  state_t state_next;

  logic                    accept;
  logic                    is_mul_op;
  logic                    is_div_op;
  logic                    is_sdiv;
  logic                    div_start;
  logic                    div_step;
  logic                    div_last;
  logic                    mul_last;
  logic [MUL_CNT_W-1:0]    mul_cnt;
  logic                    mul_signed;
  logic [DATA_WIDTH-1:0]   mul_a;
  logic [DATA_WIDTH-1:0]   mul_b;
  logic [2*DATA_WIDTH-1:0] mul_a_ext;
  logic [2*DATA_WIDTH-1:0] mul_b_ext;
  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]   abs_a;
  logic [DATA_WIDTH-1:0]   abs_b;
  logic                    sign_q;
  logic                    sign_r;
  logic [DATA_WIDTH-1:0]   quo_raw;
  logic [DATA_WIDTH-1:0]   rem_raw;
  logic [DATA_WIDTH-1:0]   quo_fix;
  logic [DATA_WIDTH-1:0]   rem_fix;
  logic                    done_r;
  logic [DATA_WIDTH-1:0]   hi_r;
  logic [DATA_WIDTH-1:0]   lo_r;

  assign accept    = start && (state == ST_IDLE) && !flush;
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_sdiv   = (op == OP_DIV);
  assign div_start = accept && is_div_op && (operand_2 != '0);
  assign div_step  = (state == ST_DIV);
  assign mul_last  = (state == ST_MUL) && (mul_cnt == MUL_CNT_W'(MUL_LATENCY - 1));

  // Two's-complement negation of the most negative value wraps to itself,
  // which is exactly the unsigned magnitude the divider needs.
  assign abs_a = (is_sdiv && operand_1[DATA_WIDTH-1]) ? -operand_1 : operand_1;
  assign abs_b = (is_sdiv && operand_2[DATA_WIDTH-1]) ? -operand_2 : operand_2;

  assign mul_a_ext = {{DATA_WIDTH{mul_signed & mul_a[DATA_WIDTH-1]}}, mul_a};
  assign mul_b_ext = {{DATA_WIDTH{mul_signed & mul_b[DATA_WIDTH-1]}}, mul_b};
  assign product   = mul_a_ext * mul_b_ext;

  assign quo_fix = sign_q ? -quo_raw : quo_raw;
  assign rem_fix = sign_r ? -rem_raw : rem_raw;

  muldiv_ctrl_div_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .step      (div_step),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .quotient  (quo_raw),
    .remainder (rem_raw),
    .last_step (div_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul_op) begin
          state_next = ST_MUL;
        end else if (accept && is_div_op) begin
          state_next = (operand_2 == '0) ? ST_DZERO : ST_DIV;
        end
      end
      ST_MUL:   if (mul_last) state_next = ST_IDLE;
      ST_DIV:   if (div_last) state_next = ST_SIGN;
      ST_SIGN:  state_next = ST_IDLE;
      ST_DZERO: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (flush) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      mul_cnt    <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
    end else begin
      if (accept && is_mul_op) begin
        mul_a      <= operand_1;
        mul_b      <= operand_2;
        mul_signed <= (op == OP_MULT);
        mul_cnt    <= '0;
      end else if (state == ST_MUL) begin
        mul_cnt <= mul_cnt + 1'b1;
      end
      if (div_start) begin
        sign_q <= is_sdiv && (operand_1[DATA_WIDTH-1] ^ operand_2[DATA_WIDTH-1]);
        sign_r <= is_sdiv && operand_1[DATA_WIDTH-1];
      end
    end
  end

  // A flush in the completion cycle discards the result and suppresses done.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= !flush && (mul_last || (state == ST_SIGN) || (state == ST_DZERO));
      if (!flush) begin
        if (accept && (op == OP_MTHI)) hi_r <= operand_1;
        if (accept && (op == OP_MTLO)) lo_r <= operand_1;
        if (mul_last) begin
          hi_r <= product[2*DATA_WIDTH-1:DATA_WIDTH];
          lo_r <= product[DATA_WIDTH-1:0];
        end
        if (state == ST_SIGN) begin
          hi_r <= rem_fix;
          lo_r <= quo_fix;
        end
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign stall_req = busy || (start && !op[2] && (state == ST_IDLE) && !flush);
  assign done      = done_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

endmodule

`default_nettype wire
